// File: rtl/speed_ctrl_pkg.sv
// speed_ctrl_pkg
//   Shared definitions for the motor speed controller: default loop rate,
//   PI shift and gain/integrator widths, plus the sequencer state and
//   clamp-sign encodings.
package speed_ctrl_pkg;

  localparam int CTRL_SAMPLE_HZ = 1000;
  localparam int CTRL_SHIFT     = 6;
  localparam int CTRL_GAIN_BITS = 8;
  localparam int CTRL_INT_BITS  = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAPT  = 3'd1,
    ERR   = 3'd2,
    PTERM = 3'd3,
    ITERM = 3'd4,
    SAT   = 3'd5
  } ctrlState_e;

  // Direction the output saturated in during the most recent SAT.
  typedef enum logic [1:0] {
    CLAMP_NONE = 2'd0,
    CLAMP_POS  = 2'd1,
    CLAMP_NEG  = 2'd2
  } clampSign_e;

endpackage

// File: rtl/speed_ctrl_tick.sv
// tick_gen
//   Periodic tick source. The counter runs 0..PERIOD-1 while en is high and
//   wraps to 0; tick is high during the wrap cycle. With en low the counter
//   is held at 0, so a fresh enable always waits a full period.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous reset, active-high
//   en    in  count enable
//   tick  out one-cycle pulse once per PERIOD cycles
module tick_gen #(
  parameter int PERIOD = 48000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/speed_ctrl.sv
// speed_ctrl
//   Closed-loop motor speed controller. Samples the QEI count once per tick,
//   takes the per-sample delta as speed, and runs a sequenced PI loop on a
//   single shared multiplier to produce PWM duty magnitude and direction.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous reset, active-high
//   en       in  loop enable; low coasts and clears all loop state
//   sp       in  signed setpoint, counts per sample
//   kp, ki   in  unsigned proportional / integral gains
//   qei_val  in  free-running QEI count (wraps)
//   duty     out PWM duty magnitude
//   dir      out 1 = negative command
//   speed    out signed measured speed of the last sample
//   upd      out one-cycle pulse when duty/dir/speed update
//   busy     out high while the sequencer is not IDLE
//
// state | meaning
// IDLE  | waiting for tick
// CAPT  | latch sp/kp/ki, sample qei_val, compute speed
// ERR   | err = sp - speed, integrator update with anti-windup
// PTERM | acc = kp * err
// ITERM | acc += ki * integ
// SAT   | shift, clamp, register duty/dir/speed, pulse upd
module speed_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 48000000,
  parameter int SAMPLE_HZ = CTRL_SAMPLE_HZ,
  parameter int QEI_BITS  = 16,
  parameter int PWM_BITS  = 10,
  parameter int GAIN_BITS = CTRL_GAIN_BITS,
  parameter int INT_BITS  = CTRL_INT_BITS,
  parameter int SHIFT     = CTRL_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [QEI_BITS-1:0]  sp,
  input  logic [GAIN_BITS-1:0] kp,
  input  logic [GAIN_BITS-1:0] ki,
  input  logic [QEI_BITS-1:0]  qei_val,
  output logic [PWM_BITS-1:0]  duty,
  output logic                 dir,
  output logic [QEI_BITS-1:0]  speed,
  output logic                 upd,
  output logic                 busy
);

  localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
  localparam int ERR_W  = QEI_BITS + 1;
  localparam int MUL_W  = GAIN_BITS + 1 + INT_BITS;
  localparam int ACC_W  = GAIN_BITS + INT_BITS + 2;

  localparam logic signed [INT_BITS:0] INT_HI = (INT_BITS + 1)'((2 ** (INT_BITS - 1)) - 1);
  localparam logic signed [INT_BITS:0] INT_LO = -INT_HI;
  localparam logic signed [ACC_W-1:0]  U_HI   = ACC_W'((2 ** PWM_BITS) - 1);
  localparam logic signed [ACC_W-1:0]  U_LO   = -U_HI;

  // The sequence is six cycles long; a shorter period would let a tick land
  // while the previous sample is still in flight.
  if (PERIOD < 8) begin : gBadPeriod
    $error("speed_ctrl: CLK_HZ/SAMPLE_HZ must be at least 8");
  end
  // err is sign-extended into the integrator-width multiplier operand.
  if (INT_BITS <= ERR_W) begin : gBadIntWidth
    $error("speed_ctrl: INT_BITS must exceed QEI_BITS+1");
  end

  ctrlState_e state, stateNext;
  clampSign_e clamp, clampNext;

  logic                        tick;
  logic [QEI_BITS-1:0]         spReg;
  logic [GAIN_BITS-1:0]        kpReg;
  logic [GAIN_BITS-1:0]        kiReg;
  logic [QEI_BITS-1:0]         prev;
  logic                        valid;
  logic [QEI_BITS-1:0]         speedCur;
  logic signed [ERR_W-1:0]     errReg;
  logic signed [INT_BITS-1:0]  integ;
  logic signed [ACC_W-1:0]     acc;

  logic signed [ERR_W-1:0]     errNext;
  logic signed [INT_BITS:0]    integSum;
  logic signed [INT_BITS-1:0]  integSat;
  logic                        holdInteg;
  logic signed [GAIN_BITS:0]   mulA;
  logic signed [INT_BITS-1:0]  mulB;
  logic signed [MUL_W-1:0]     product;
  logic signed [ACC_W-1:0]     productExt;
  logic signed [ACC_W-1:0]     uShift;
  logic signed [ACC_W-1:0]     uSat;
  logic                        uNeg;

  tick_gen #(
    .PERIOD (PERIOD)
  ) uTick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (tick) stateNext = CAPT;
      CAPT:    stateNext = ERR;
      ERR:     stateNext = PTERM;
      PTERM:   stateNext = ITERM;
      ITERM:   stateNext = SAT;
      SAT:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (!en) begin
      stateNext = IDLE;
    end
  end

  assign busy = (state != IDLE);

  // Error and saturating integrator candidate.
  always_comb begin
    errNext  = $signed({spReg[QEI_BITS-1], spReg}) - $signed({speedCur[QEI_BITS-1], speedCur});
    integSum = {integ[INT_BITS-1], integ} + {{(INT_BITS + 1 - ERR_W){errNext[ERR_W-1]}}, errNext};
    integSat = integSum[INT_BITS-1:0];
    if (integSum > INT_HI) begin
      integSat = INT_HI[INT_BITS-1:0];
    end else if (integSum < INT_LO) begin
      integSat = INT_LO[INT_BITS-1:0];
    end
    // Don't wind further into a clamp the output is already pinned against.
    holdInteg = ((clamp == CLAMP_POS) && !errNext[ERR_W-1] && (errNext != '0)) ||
                ((clamp == CLAMP_NEG) &&  errNext[ERR_W-1]);
  end

  // One signed multiplier: kp*err in PTERM, ki*integ in ITERM.
  always_comb begin
    if (state == ITERM) begin
      mulA = {1'b0, kiReg};
      mulB = integ;
    end else begin
      mulA = {1'b0, kpReg};
      mulB = {{(INT_BITS - ERR_W){errReg[ERR_W-1]}}, errReg};
    end
    product    = mulA * mulB;
    productExt = {product[MUL_W-1], product};
  end

  always_comb begin
    uShift    = acc >>> SHIFT;
    uSat      = uShift;
    clampNext = CLAMP_NONE;
    if (uShift > U_HI) begin
      uSat      = U_HI;
      clampNext = CLAMP_POS;
    end else if (uShift < U_LO) begin
      uSat      = U_LO;
      clampNext = CLAMP_NEG;
    end
    uNeg = uSat[ACC_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      spReg    <= '0;
      kpReg    <= '0;
      kiReg    <= '0;
      prev     <= '0;
      valid    <= 1'b0;
      speedCur <= '0;
      errReg   <= '0;
      integ    <= '0;
      acc      <= '0;
      clamp    <= CLAMP_NONE;
      duty     <= '0;
      dir      <= 1'b0;
      speed    <= '0;
      upd      <= 1'b0;
    end else begin
      upd <= 1'b0;
      case (state)
        CAPT: begin
          spReg    <= sp;
          kpReg    <= kp;
          kiReg    <= ki;
          prev     <= qei_val;
          valid    <= 1'b1;
          // Modulo subtraction makes counter wrap transparent.
          speedCur <= valid ? (qei_val - prev) : '0;
        end
        ERR: begin
          errReg <= errNext;
          if (!holdInteg) begin
            integ <= integSat;
          end
        end
        PTERM: acc <= productExt;
        ITERM: acc <= acc + productExt;
        SAT: begin
          duty  <= uNeg ? PWM_BITS'(-uSat) : PWM_BITS'(uSat);
          dir   <= uNeg;
          speed <= speedCur;
          upd   <= 1'b1;
          clamp <= clampNext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_speed_ctrl.sv
// Testbench for speed_ctrl. Instance A runs with SHIFT=0, instance B with
// SHIFT=2; both use a 10-cycle sample period. Expected updates are queued by
// the stimulus and checked by per-instance monitors on every upd pulse.
module tb_speed_ctrl;

  typedef struct {
    logic [9:0]  duty;
    logic        dir;
    logic [15:0] speed;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enA = 1'b0;
  logic        enB = 1'b0;
  logic [15:0] sp  = '0;
  logic [7:0]  kp  = '0;
  logic [7:0]  ki  = '0;
  logic [15:0] qei = '0;

  logic [9:0]  dutyA, dutyB;
  logic        dirA, dirB;
  logic [15:0] speedA, speedB;
  logic        updA, updB, busyA, busyB;

  int   errors = 0;
  int   checks = 0;
  exp_t qA[$];
  exp_t qB[$];

  always #5 clk = ~clk;

  speed_ctrl #(
    .CLK_HZ(1000), .SAMPLE_HZ(100), .QEI_BITS(16), .PWM_BITS(10),
    .GAIN_BITS(8), .INT_BITS(24), .SHIFT(0)
  ) dutA (
    .clk(clk), .rst(rst), .en(enA), .sp(sp), .kp(kp), .ki(ki), .qei_val(qei),
    .duty(dutyA), .dir(dirA), .speed(speedA), .upd(updA), .busy(busyA)
  );

  speed_ctrl #(
    .CLK_HZ(1000), .SAMPLE_HZ(100), .QEI_BITS(16), .PWM_BITS(10),
    .GAIN_BITS(8), .INT_BITS(24), .SHIFT(2)
  ) dutB (
    .clk(clk), .rst(rst), .en(enB), .sp(sp), .kp(kp), .ki(ki), .qei_val(qei),
    .duty(dutyB), .dir(dirB), .speed(speedB), .upd(updB), .busy(busyB)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (updA) begin
      if (qA.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL A.upd: got unexpected update expected none at %0t", $time);
      end else begin
        e = qA.pop_front();
        chk("A.duty", 32'(dutyA), 32'(e.duty));
        chk("A.dir", 32'(dirA), 32'(e.dir));
        chk("A.speed", 32'(speedA), 32'(e.speed));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (updB) begin
      if (qB.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL B.upd: got unexpected update expected none at %0t", $time);
      end else begin
        e = qB.pop_front();
        chk("B.duty", 32'(dutyB), 32'(e.duty));
        chk("B.dir", 32'(dirB), 32'(e.dir));
        chk("B.speed", 32'(speedB), 32'(e.speed));
      end
    end
  end

  task automatic pushExp(input bit useB, input logic [9:0] d, input logic r, input logic [15:0] s);
    exp_t e;
    e.duty  = d;
    e.dir   = r;
    e.speed = s;
    if (useB) qB.push_back(e);
    else      qA.push_back(e);
  endtask

  task automatic waitUpd(input bit useB);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(useB ? updB : updA) && n < 40);
    if (!(useB ? updB : updA)) begin
      checks++;
      errors++;
      $display("FAIL upd.timeout: got no update expected one within 40 cycles at %0t", $time);
    end
  endtask

  task automatic runSample(input bit useB, input logic [15:0] q, input logic [15:0] s,
                           input logic [7:0] p, input logic [7:0] i,
                           input logic [9:0] eDuty, input logic eDir, input logic [15:0] eSpeed);
    qei = q;
    sp  = s;
    kp  = p;
    ki  = i;
    pushExp(useB, eDuty, eDir, eSpeed);
    waitUpd(useB);
  endtask

  initial begin
    int n;
    int d;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.duty", 32'(dutyA), 0);
    chk("rst.dir", 32'(dirA), 0);
    chk("rst.speed", 32'(speedA), 0);
    chk("rst.upd", 32'(updA), 0);
    chk("rst.busy", 32'(busyA), 0);

    // Enable B: first tick after a full period, busy T+1..T+5, upd at T+6
    qei = 16'h0000;
    sp  = 16'd50;
    kp  = 8'd4;
    ki  = 8'd0;
    pushExp(1'b1, 10'd50, 1'b0, 16'd0);
    enB = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("lat.busy", 32'(busyB), 32'((k >= 10) && (k <= 14)));
      chk("lat.upd", 32'(updB), 32'(k == 15));
      if (k < 15) chk("lat.duty", 32'(dutyB), 0);
    end
    @(negedge clk);
    chk("upd.pulse", 32'(updB), 0);
    chk("hold.duty", 32'(dutyB), 50);
    repeat (3) runSample(1'b1, 16'h0000, 16'd50, 8'd4, 8'd0, 10'd50, 1'b0, 16'd0);
    enB = 1'b0;

    // Instance A: wrap-around speed, gains zero
    qei = 16'hFFF0;
    sp  = 16'd0;
    kp  = 8'd0;
    ki  = 8'd0;
    pushExp(1'b0, 10'd0, 1'b0, 16'd0);
    enA = 1'b1;
    waitUpd(1'b0);
    runSample(1'b0, 16'h0010, 16'd0, 8'd0, 8'd0, 10'd0, 1'b0, 16'd32);
    runSample(1'b0, 16'hFFF0, 16'd0, 8'd0, 8'd0, 10'd0, 1'b0, 16'hFFE0);

    // Proportional saturation both ways
    runSample(1'b0, 16'hFFF0, 16'd1000, 8'd255, 8'd0, 10'd1023, 1'b0, 16'd0);
    runSample(1'b0, 16'hFFF0, 16'hFC18, 8'd255, 8'd0, 10'd1023, 1'b1, 16'd0);

    // Integral ramp, clamp, anti-windup release
    for (int k = 1; k <= 107; k++) begin
      d = (10 * k > 1023) ? 1023 : 10 * k;
      runSample(1'b0, 16'hFFF0, 16'd10, 8'd0, 8'd1, 10'(d), 1'b0, 16'd0);
    end
    runSample(1'b0, 16'hFFF0, 16'hFFF6, 8'd0, 8'd1, 10'd1020, 1'b0, 16'd0);
    runSample(1'b0, 16'hFFF0, 16'hFFF6, 8'd0, 8'd1, 10'd1010, 1'b0, 16'd0);

    // Drop en during PTERM
    n = 0;
    while (!busyA && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drop.seen_busy", 32'(busyA), 1);
    @(negedge clk);
    @(negedge clk);
    enA = 1'b0;
    @(negedge clk);
    chk("drop.busy", 32'(busyA), 0);
    chk("drop.duty", 32'(dutyA), 0);
    chk("drop.dir", 32'(dirA), 0);
    chk("drop.upd", 32'(updA), 0);
    chk("drop.speed", 32'(speedA), 0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (updA) n++;
    end
    chk("drop.noupd", 32'(n), 0);

    // Re-enable: integrator and prev cleared
    qei = 16'h1234;
    sp  = 16'd20;
    kp  = 8'd0;
    ki  = 8'd1;
    pushExp(1'b0, 10'd20, 1'b0, 16'd0);
    enA = 1'b1;
    waitUpd(1'b0);
    runSample(1'b0, 16'h1239, 16'd20, 8'd0, 8'd1, 10'd35, 1'b0, 16'd5);

    repeat (3) @(negedge clk);
    chk("qA.empty", 32'(qA.size()), 0);
    chk("qB.empty", 32'(qB.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
